cache_split3_3b: RTL and testbench

CACHE_SPLIT3_3B -- requirements
Module: cache_split3_3b

---
 rtl/cache_split3_3b.sv | 169 ++++++++++++++++
 tb/tb_cache_split3_3b.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cache_split3_3b.sv
// Three-way token splitter: each upstream token is routed into one of three
// per-channel FIFOs, each drained by its own IDLE/BUSY handshake FSM.
module cache_split3_3b #(
    parameter int DW    = 3,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_drive,
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_data,
    output logic          o_free,
    output logic          o_drive0,
    output logic          o_drive1,
    output logic          o_drive2,
    output logic [DW-1:0] o_data0,
    output logic [DW-1:0] o_data1,
    output logic [DW-1:0] o_data2,
    input  logic          i_free0,
    input  logic          i_free1,
    input  logic          i_free2,
    output logic          o_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, BUSY} ch_state_e;

    ch_state_e     state_q   [3];
    ch_state_e     state_d   [3];
    logic [DW-1:0] mem_q     [3][DEPTH];
    logic [DW-1:0] mem_d     [3][DEPTH];
    logic [AW-1:0] rd_ptr_q  [3];
    logic [AW-1:0] rd_ptr_d  [3];
    logic [AW-1:0] wr_ptr_q  [3];
    logic [AW-1:0] wr_ptr_d  [3];
    logic [CW-1:0] cnt_q     [3];
    logic [CW-1:0] cnt_d     [3];
    logic [2:0]    drive_q, drive_d;
    logic          hold_valid_q, hold_valid_d;
    logic [1:0]    hold_sel_q, hold_sel_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          free_q, free_d;
    logic          err_q, err_d;

    logic          push_en;
    logic [1:0]    push_sel;
    logic [DW-1:0] push_data;
    logic [1:0]    tgt_sel;
    logic [CW-1:0] tgt_cnt;
    logic [2:0]    free_vec;
    logic          pop;
    logic          push_here;

    assign free_vec = {i_free2, i_free1, i_free0};

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        drive_d      = '0;
        hold_valid_d = hold_valid_q;
        hold_sel_d   = hold_sel_q;
        hold_data_d  = hold_data_q;
        free_d       = 1'b0;
        err_d        = err_q;
        push_en      = 1'b0;
        push_sel     = '0;
        push_data    = '0;
        pop          = 1'b0;
        push_here    = 1'b0;

        tgt_sel = hold_valid_q ? hold_sel_q : i_sel;
        case (tgt_sel)
            2'd0:    tgt_cnt = cnt_q[0];
            2'd1:    tgt_cnt = cnt_q[1];
            2'd2:    tgt_cnt = cnt_q[2];
            default: tgt_cnt = '0;
        endcase

        // A held token blocks new input; it retires once its FIFO has room pre-pop.
        if (hold_valid_q) begin
            if (i_drive) err_d = 1'b1;
            if (tgt_cnt < CW'(DEPTH)) begin
                push_en      = 1'b1;
                push_sel     = hold_sel_q;
                push_data    = hold_data_q;
                hold_valid_d = 1'b0;
                free_d       = 1'b1;
            end
        end else if (i_drive) begin
            if (i_sel == 2'd3) begin
                free_d = 1'b1;
                err_d  = 1'b1;
            end else if (tgt_cnt < CW'(DEPTH)) begin
                push_en   = 1'b1;
                push_sel  = i_sel;
                push_data = i_data;
                free_d    = 1'b1;
            end else begin
                hold_valid_d = 1'b1;
                hold_sel_d   = i_sel;
                hold_data_d  = i_data;
            end
        end

        for (int ch = 0; ch < 3; ch++) begin
            pop       = (state_q[ch] == BUSY) && free_vec[ch];
            push_here = push_en && (push_sel == 2'(ch));
            if ((state_q[ch] == IDLE) && free_vec[ch]) err_d = 1'b1;
            if (push_here) begin
                mem_d[ch][wr_ptr_q[ch]] = push_data;
                wr_ptr_d[ch] = wr_ptr_q[ch] + AW'(1);
            end
            if (pop) begin
                rd_ptr_d[ch] = rd_ptr_q[ch] + AW'(1);
                state_d[ch]  = IDLE;
            end
            cnt_d[ch] = cnt_q[ch] + CW'(push_here) - CW'(pop);
            // Offer as soon as data is present, including a token landing this edge.
            if ((state_q[ch] == IDLE) && ((cnt_q[ch] != '0) || push_here)) begin
                state_d[ch] = BUSY;
                drive_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                state_q[ch]  <= IDLE;
                rd_ptr_q[ch] <= '0;
                wr_ptr_q[ch] <= '0;
                cnt_q[ch]    <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[ch][i] <= '0;
            end
            drive_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_sel_q   <= '0;
            hold_data_q  <= '0;
            free_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            drive_q      <= drive_d;
            hold_valid_q <= hold_valid_d;
            hold_sel_q   <= hold_sel_d;
            hold_data_q  <= hold_data_d;
            free_q       <= free_d;
            err_q        <= err_d;
        end
    end

    assign o_free   = free_q;
    assign o_err    = err_q;
    assign o_drive0 = drive_q[0];
    assign o_drive1 = drive_q[1];
    assign o_drive2 = drive_q[2];
    assign o_data0  = (state_q[0] == BUSY) ? mem_q[0][rd_ptr_q[0]] : '0;
    assign o_data1  = (state_q[1] == BUSY) ? mem_q[1][rd_ptr_q[1]] : '0;
    assign o_data2  = (state_q[2] == BUSY) ? mem_q[2][rd_ptr_q[2]] : '0;

endmodule

// File: tb/tb_cache_split3_3b.sv
// Directed table-driven bench for cache_split3_3b, plus hand sequences for
// pointer wrap and simultaneous push/pop on a full channel.
module tb_cache_split3_3b;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_drive = 1'b0;
    logic [1:0] i_sel = '0;
    logic [2:0] i_data = '0;
    logic       i_free0 = 1'b0, i_free1 = 1'b0, i_free2 = 1'b0;
    logic       o_free, o_drive0, o_drive1, o_drive2, o_err;
    logic [2:0] o_data0, o_data1, o_data2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       drv;
        logic [1:0] sel;
        logic [2:0] data;
        logic [2:0] free;
        logic       e_free;
        logic [2:0] e_drv;
        logic [2:0] e_d0;
        logic [2:0] e_d1;
        logic [2:0] e_d2;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    cache_split3_3b #(.DW(3), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
        .o_free(o_free), .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
        .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
        .i_free0(i_free0), .i_free1(i_free1), .i_free2(i_free2), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Inputs are held across one rising edge; outputs are sampled 1ns later.
    task automatic apply_stimulus(input logic r, input logic d, input logic [1:0] s,
                                  input logic [2:0] dat, input logic [2:0] f);
        rst = r; i_drive = d; i_sel = s; i_data = dat;
        {i_free2, i_free1, i_free0} = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic ef, input logic [2:0] edrv,
                                input logic [2:0] ed0, input logic [2:0] ed1,
                                input logic [2:0] ed2, input logic eerr);
        logic [13:0] got, exp;
        got = {o_free, o_drive2, o_drive1, o_drive0, o_data0, o_data1, o_data2, o_err};
        exp = {ef, edrv, ed0, ed1, ed2, eerr};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got free/drv/d0/d1/d2/err=%b/%b/%0d/%0d/%0d/%b required %b/%b/%0d/%0d/%0d/%b",
                     name, got[13], got[12:10], got[9:7], got[6:4], got[3:1], got[0],
                     ef, edrv, ed0, ed1, ed2, eerr);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic [1:0] s, input logic [2:0] dat,
                       input logic [2:0] f, input logic ef, input logic [2:0] edrv,
                       input logic [2:0] ed0, input logic [2:0] ed1, input logic [2:0] ed2,
                       input logic eerr);
        vec_t v;
        v.rst = r; v.drv = d; v.sel = s; v.data = dat; v.free = f;
        v.e_free = ef; v.e_drv = edrv; v.e_d0 = ed0; v.e_d1 = ed1; v.e_d2 = ed2; v.e_err = eerr;
        tbl.push_back(v);
    endtask

    initial begin
        // reset state, then single token to channel 1 and its release
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(0,1,1,5,3'b000, 1,3'b010,0,5,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,5,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,5,0,0);
        add(0,0,0,0,3'b010, 0,3'b000,0,0,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        // illegal destination: dropped, freed, sticky error
        add(0,1,3,7,3'b000, 1,3'b000,0,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,1);
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        // free on an idle channel
        add(0,0,0,0,3'b010, 0,3'b000,0,0,0,1);
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        // channel 0 overflow into the holding register, plus a drive while pending
        add(0,1,0,1,3'b000, 1,3'b001,1,0,0,0);
        add(0,1,0,2,3'b000, 1,3'b000,1,0,0,0);
        add(0,1,0,3,3'b000, 0,3'b000,1,0,0,0);
        add(0,1,1,6,3'b000, 0,3'b000,1,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b000,1,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b000,1,0,0,1);
        add(0,0,0,0,3'b001, 0,3'b000,0,0,0,1);
        add(0,0,0,0,3'b000, 1,3'b001,2,0,0,1);
        add(0,0,0,0,3'b001, 0,3'b000,0,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b001,3,0,0,1);
        add(0,0,0,0,3'b001, 0,3'b000,0,0,0,1);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,1);
        // channel 2 stalled full while channel 0 keeps flowing
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(0,1,2,4,3'b000, 1,3'b100,0,0,4,0);
        add(0,1,2,5,3'b000, 1,3'b000,0,0,4,0);
        add(0,1,2,6,3'b000, 0,3'b000,0,0,4,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,4,0);
        add(0,0,0,0,3'b100, 0,3'b000,0,0,0,0);
        add(0,0,0,0,3'b000, 1,3'b100,0,0,5,0);
        add(0,1,0,7,3'b000, 1,3'b001,7,0,5,0);
        add(0,0,0,0,3'b001, 0,3'b000,0,0,5,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,5,0);
        // tokens on every channel, then reset discards them all
        add(0,1,0,1,3'b000, 1,3'b001,1,0,5,0);
        add(0,1,1,2,3'b000, 1,3'b010,1,2,5,0);
        add(1,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,0);
        add(1,1,0,3,3'b000, 0,3'b000,0,0,0,0);
        add(0,0,0,0,3'b000, 0,3'b000,0,0,0,0);

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].rst, tbl[i].drv, tbl[i].sel, tbl[i].data, tbl[i].free);
            check_output($sformatf("row%0d", i), tbl[i].e_free, tbl[i].e_drv,
                         tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_d2, tbl[i].e_err);
        end

        // pointer wrap on channel 1: five tokens through a depth-2 FIFO
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 1, 1, 3'(k + 1), 3'b000);
            check_output($sformatf("wrap_offer%0d", k), 1, 3'b010, 0, 3'(k + 1), 0, 0);
            apply_stimulus(0, 0, 0, 0, 3'b010);
            check_output($sformatf("wrap_free%0d", k), 0, 3'b000, 0, 0, 0, 0);
        end

        // push and pop at the same edge on a full FIFO: pre-pop count forces the hold
        apply_stimulus(0, 1, 1, 1, 3'b000);
        check_output("pp_fill1", 1, 3'b010, 0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 2, 3'b000);
        check_output("pp_fill2", 1, 3'b000, 0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 3, 3'b010);
        check_output("pp_held", 0, 3'b000, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 3'b000);
        check_output("pp_release", 1, 3'b010, 0, 2, 0, 0);
        apply_stimulus(0, 0, 0, 0, 3'b010);
        check_output("pp_pop2", 0, 3'b000, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 3'b000);
        check_output("pp_offer3", 0, 3'b010, 0, 3, 0, 0);
        apply_stimulus(0, 0, 0, 0, 3'b010);
        check_output("pp_pop3", 0, 3'b000, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 3'b000);
        check_output("pp_empty", 0, 3'b000, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
